// File: rtl/output_buffer_pkg.sv
// Shared constants, counter-width helper and capture FSM encoding for output_buffer.
package output_buffer_pkg;

    localparam int unsigned R_LSB     = 24;
    localparam int unsigned G_LSB     = 16;
    localparam int unsigned B_LSB     = 8;
    localparam int unsigned COL_CNT_W = 16;

    typedef enum logic {
        IDLE,
        CAPTURE
    } cap_state_t;

    // Bits needed to hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/output_buffer_if.sv
// AXI-Stream bundle driven by output_buffer (master) towards the downstream sink (slave).
interface output_buffer_if #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32
);
    logic                              m_tvalid;
    logic                              m_tready;
    logic [C_AXIS_TDATA_WIDTH-1:0]     m_tdata;
    logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_tstrb;
    logic                              m_tlast;

    modport master (output m_tvalid, m_tdata, m_tstrb, m_tlast, input m_tready);
    modport slave  (input m_tvalid, m_tdata, m_tstrb, m_tlast, output m_tready);
endinterface

// File: rtl/output_buffer_tag_delay_line.sv
// Enable-gated DEPTH-deep shifter that keeps the column tag aligned with processed pixels.
module tag_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tag_in,
    output logic tag_out
);
    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, en};
            assign tag_out     = tag_in;
        end else begin : g_shift
            logic [DEPTH-1:0] sr;
            always_ff @(posedge clk) begin
                if (rst)      sr <= '0;
                else if (en)  sr <= DEPTH'({sr, tag_in});
            end
            assign tag_out = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/output_buffer.sv
// AXI-Stream master: packs valid pixel columns into beats with tlast per column.
// Optional OUTPUT_BUFFER_SKID_EN swaps the single output register for a 2-entry skid FIFO.
module output_buffer
    import output_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned OUTPUT_HEIGHT      = 480,
    parameter int unsigned PROC_LATENCY       = 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] proc_R,
    input  logic [DATA_WIDTH-1:0] proc_G,
    input  logic [DATA_WIDTH-1:0] proc_B,
    input  logic                  is_full_columns_first_input,
    input  logic                  data_flowing,
    output logic                  output_has_back_pressure,
    output logic                  overrun_err,
    output logic [COL_CNT_W-1:0]  col_count,
    output_buffer_if.master       axis
);
    localparam int unsigned ROW_W = cnt_width(OUTPUT_HEIGHT);
    localparam int unsigned TW    = C_AXIS_TDATA_WIDTH;

    logic             tag_out;
    cap_state_t       state, state_nxt;
    logic [ROW_W-1:0] row_cnt, row_cnt_nxt;
    logic             cap_c, cap_last_c, overrun_c;
    logic [TW-1:0]    beat_c;

    tag_delay_line #(.DEPTH(PROC_LATENCY)) u_tag_delay (
        .clk     (aclk),
        .rst     (areset),
        .en      (data_flowing),
        .tag_in  (is_full_columns_first_input),
        .tag_out (tag_out)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            row_cnt <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_cnt_nxt;
        end
    end

    // Column capture: row_cnt counts the rows still owed by the open column.
    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        cap_c       = 1'b0;
        cap_last_c  = 1'b0;
        overrun_c   = 1'b0;
        if (data_flowing) begin
            case (state)
                IDLE: begin
                    if (tag_out) begin
                        cap_c = 1'b1;
                        if (OUTPUT_HEIGHT == 1) begin
                            cap_last_c  = 1'b1;
                            row_cnt_nxt = '0;
                        end else begin
                            state_nxt   = CAPTURE;
                            row_cnt_nxt = ROW_W'(OUTPUT_HEIGHT - 1);
                        end
                    end
                end
                CAPTURE: begin
                    cap_c = 1'b1;
                    if (tag_out) begin
                        overrun_c   = 1'b1;
                        row_cnt_nxt = ROW_W'(OUTPUT_HEIGHT - 1);
                    end else if (row_cnt == ROW_W'(1)) begin
                        cap_last_c  = 1'b1;
                        state_nxt   = IDLE;
                        row_cnt_nxt = '0;
                    end else begin
                        row_cnt_nxt = row_cnt - ROW_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            overrun_err <= 1'b0;
            col_count   <= '0;
        end else begin
            if (overrun_c)  overrun_err <= 1'b1;
            if (cap_last_c) col_count   <= col_count + COL_CNT_W'(1);
        end
    end

    always_comb begin
        beat_c                       = '0;
        beat_c[R_LSB +: DATA_WIDTH]  = proc_R;
        beat_c[G_LSB +: DATA_WIDTH]  = proc_G;
        beat_c[B_LSB +: DATA_WIDTH]  = proc_B;
    end

    assign axis.m_tstrb = '1;

`ifdef OUTPUT_BUFFER_SKID_EN
    logic [TW-1:0] skid_data;
    logic          skid_last;
    logic          skid_valid;
    logic          take_c;

    // An occupied skid entry means both slots are held: that is the full flag.
    assign output_has_back_pressure = skid_valid;
    assign take_c                   = !axis.m_tvalid || axis.m_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            axis.m_tvalid <= 1'b0;
            axis.m_tdata  <= '0;
            axis.m_tlast  <= 1'b0;
            skid_data     <= '0;
            skid_last     <= 1'b0;
            skid_valid    <= 1'b0;
        end else if (take_c) begin
            if (skid_valid) begin
                axis.m_tvalid <= 1'b1;
                axis.m_tdata  <= skid_data;
                axis.m_tlast  <= skid_last;
                skid_valid    <= cap_c;
                if (cap_c) begin
                    skid_data <= beat_c;
                    skid_last <= cap_last_c;
                end
            end else if (cap_c) begin
                axis.m_tvalid <= 1'b1;
                axis.m_tdata  <= beat_c;
                axis.m_tlast  <= cap_last_c;
            end else begin
                axis.m_tvalid <= 1'b0;
            end
        end else if (cap_c) begin
            skid_data  <= beat_c;
            skid_last  <= cap_last_c;
            skid_valid <= 1'b1;
        end
    end
`else
    assign output_has_back_pressure = axis.m_tvalid && !axis.m_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            axis.m_tvalid <= 1'b0;
            axis.m_tdata  <= '0;
            axis.m_tlast  <= 1'b0;
        end else if (cap_c) begin
            axis.m_tvalid <= 1'b1;
            axis.m_tdata  <= beat_c;
            axis.m_tlast  <= cap_last_c;
        end else if (axis.m_tvalid && axis.m_tready) begin
            axis.m_tvalid <= 1'b0;
        end
    end
`endif

    // Upstream must freeze while back-pressure is raised.
    no_capture_under_back_pressure: assert property (
        @(posedge aclk) disable iff (areset) !(data_flowing && output_has_back_pressure)
    );

endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- AXI-Stream master end of the filter pipeline; mirror of the column input buffer.
- Takes the per-cycle RGB pixel from the processing block and uses the input buffer's `is_full_columns_first_input` / `data_flowing` side-band to pick out valid pixels. Padding and partial-column results are discarded.
- Valid pixels are packed into 32-bit beats, one column of OUTPUT_HEIGHT beats per packet, with tlast on the last beat.
- Drives `output_has_back_pressure` back to the input buffer to freeze the whole pipeline.

Parameters:
- DATA_WIDTH, 8, bits per colour channel.
- C_AXIS_TDATA_WIDTH, 32, m_tdata width; must be ≥ 3*DATA_WIDTH.
- OUTPUT_HEIGHT, 480, valid pixels per column (= beats per packet).
- PROC_LATENCY, 1, enabled pipeline stages inside the processing block; 0 = combinational.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  reset, synchronous and active-high.
- proc_R  in  DATA_WIDTH  processed red pixel for this cycle.
- proc_G  in  DATA_WIDTH  processed green pixel.
- proc_B  in  DATA_WIDTH  processed blue pixel.
- is_full_columns_first_input  in  1  tag: first row of a fully populated column entering the processing block.
- data_flowing  in  1  pipeline advance enable (write or padding cycle).
- output_has_back_pressure  out  1  high = whole pipeline must hold.
- m_tvalid  out  1  AXIS valid.
- m_tready  in  1  AXIS ready.
- m_tdata  out  C_AXIS_TDATA_WIDTH  {R,G,B,zero pad}, R in [31:24], G [23:16], B [15:8], [7:0]=0.
- m_tstrb  out  C_AXIS_TDATA_WIDTH/8  constant all ones.
- m_tlast  out  1  last beat of a column.
- overrun_err  out  1  sticky: a new tag arrived mid-column.
- col_count  out  16  columns fully emitted, wraps at 2^16.

Behaviour:
- Reset: m_tvalid=0, m_tdata=0, m_tlast=0, overrun_err=0, col_count=0, tag delay line cleared, capture idle. Any beat in flight is dropped. Reset mid-column abandons that column; no tlast is emitted for it.
- Tag delay line:
  - PROC_LATENCY-deep shift register of `is_full_columns_first_input`, shifted only on cycles with `data_flowing`=1.
  - Its output (`tag_out`) is aligned with the proc_* pixel of the same cycle.
  - PROC_LATENCY=0 means `tag_out` is the input tag directly.
- Capture FSM, states IDLE and CAPTURE, with row counter `row_cnt` of width clog2(OUTPUT_HEIGHT+1):
  - IDLE: on `data_flowing` && `tag_out`, capture the pixel, set `row_cnt`=OUTPUT_HEIGHT-1 and go to CAPTURE. If OUTPUT_HEIGHT==1, emit with tlast and stay IDLE.
  - CAPTURE: each `data_flowing` cycle captures one pixel and decrements `row_cnt`. The capture at `row_cnt`==1 carries tlast, increments `col_count` and returns to IDLE.
  - CAPTURE with `tag_out` && `data_flowing` before the column finishes: set overrun_err=1 (sticky until reset), capture the pixel as row 0 of a new column, reload `row_cnt`. The aborted column gets no tlast and is not counted.
  - Cycles without `data_flowing` change no state.
  - `data_flowing` in IDLE without `tag_out`: pixel discarded.
- Output register (default build): one entry.
  - `output_has_back_pressure` = m_tvalid && !m_tready (combinational).
  - Capture writes the register and sets m_tvalid=1.
  - A handshake with no capture in the same cycle clears m_tvalid.
  - Handshake and capture in the same cycle reload the register: full throughput, one beat per cycle.
  - Latency: captured pixel visible on m_tdata the cycle after capture.
  - `data_flowing` is guaranteed low while back-pressure is high. Assert this in simulation; a capture into an unconsumed register is a bench error.
- AXIS rules: m_tdata, m_tlast held stable while m_tvalid && !m_tready. m_tvalid never drops without a handshake, except on reset.

Optional Feature:
- Macro OUTPUT_BUFFER_SKID_EN.
- When defined: two-entry skid FIFO replaces the output register.
  - `output_has_back_pressure` = registered FIFO-full flag, which removes the combinational m_tready→tready path.
  - Asserts when 1 entry is held and a capture occurs without a handshake. Deasserts the cycle after occupancy drops below 2.
  - The second entry absorbs the one in-flight capture.
  - Order preserved; tlast travels with its beat.
- When undefined: single register and combinational back-pressure as above.

Decomposition:
- Package output_buffer_pkg: byte-lane offset constants (R_LSB=24, G_LSB=16, B_LSB=8), clog2-derived counter widths, FSM state enum {IDLE, CAPTURE}.
- One sub-module, tag_delay_line: enable-gated PROC_LATENCY-deep 1-bit shifter, with a PROC_LATENCY==0 bypass.

Test Plan:
- OUTPUT_HEIGHT=4, PROC_LATENCY=2, m_tready=1. Tag at cycle 0 with `data_flowing` continuous, pixels R=0x10+n → beats R=0x12..0x15 on consecutive cycles starting cycle 3. tlast on 0x15, col_count=1.
- Same setup, m_tready held 0 for 3 cycles after the first beat → `output_has_back_pressure`=1 for those cycles, m_tdata stable at 0x12_xx_xx_00. No beat lost; 4 beats total.
- `data_flowing` toggled 1010… → tag delay advances only on enabled cycles. Beats match the enabled-cycle pixels only; discarded padding pixels never appear.
- Second tag arriving after 2 captured rows → overrun_err=1. No tlast for the first column; the next 4 beats form a full column with tlast; col_count=1.
- areset asserted mid-column with m_tvalid=1 → next cycle m_tvalid=0, col_count=0, FSM IDLE. A fresh tag yields a clean 4-beat column.
- With OUTPUT_BUFFER_SKID_EN and random m_tready at 50% → beat sequence is identical to the m_tready=1 run. Back-pressure shows no same-cycle dependence on m_tready.
